// File: rtl/redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller.
// Covers the state encoding, the PC step and the counter widths.
package redirect_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_REFILL   = 2'd2
   } state_e;

   localparam int          CNT_W    = 16;
   localparam int          REFILL_W = 3;
   localparam logic [31:0] PC_INC   = 32'd4;

   // Sequential successor of a PC; wraps silently at 2^32.
   function automatic logic [31:0] pc_seq(input logic [31:0] pc);
      return pc + PC_INC;
   endfunction

endpackage

// File: rtl/redirect_ctrl_if.sv
// Fetch/execute side bundle of the redirect controller.
// The pipeline drives it through master; the controller responds through slave.
interface redirect_ctrl_if;
   import redirect_ctrl_pkg::*;

   logic             stall;
   logic [31:0]      IFpc;
   logic             IFpcchoose;
   logic [31:0]      IFnpc;
   logic             Ex_valid;
   logic [31:0]      Expc;
   logic [31:0]      Exnpc;
   logic             Expcchoose;
   logic             isjmp;

   logic [31:0]      next_pc;
   logic             pc_we;
   logic             flush;
   logic [1:0]       state;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispred_cnt;

   modport master (
      output stall, IFpc, IFpcchoose, IFnpc, Ex_valid, Expc, Exnpc, Expcchoose, isjmp,
      input  next_pc, pc_we, flush, state, branch_cnt, mispred_cnt
   );

   modport slave (
      input  stall, IFpc, IFpcchoose, IFnpc, Ex_valid, Expc, Exnpc, Expcchoose, isjmp,
      output next_pc, pc_we, flush, state, branch_cnt, mispred_cnt
   );

endinterface

// File: rtl/redirect_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Cleared asynchronously by the active-low reset.
module redirect_ctrl_sat_counter
   import redirect_ctrl_pkg::*;
(
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/redirect_ctrl.sv
// Fetch redirect controller: picks the next PC, flushes on a mispredicted
// branch and masks BHT predictions while the front end refills.
module redirect_ctrl
   import redirect_ctrl_pkg::*;
#(
   parameter int          REFILL_CYCLES = 2,
   parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
   input  logic          clk_sys,
   input  logic          rst_n,
   redirect_ctrl_if.slave bus
);

   if ((REFILL_CYCLES < 1) || (REFILL_CYCLES > 7)) begin : g_bad_param
      $error("redirect_ctrl: REFILL_CYCLES must be in 1..7");
   end

   localparam logic [REFILL_W-1:0] REFILL_LOAD = REFILL_W'(REFILL_CYCLES - 1);

   state_e              state_q;
   state_e              state_d;
   logic [REFILL_W-1:0] refill_q;
   logic [REFILL_W-1:0] refill_d;

   logic                mispredict;
   logic                resolve;
   logic [31:0]         correction_pc;
   logic [31:0]         seq_pc;

   // Resolutions only count in RUN; REDIRECT and REFILL see bubbles in EX.
   assign resolve       = (state_q == ST_RUN) && bus.Ex_valid;
   assign mispredict    = resolve && (bus.Expcchoose != bus.isjmp);
   assign correction_pc = bus.isjmp ? bus.Exnpc : pc_seq(bus.Expc);
   assign seq_pc        = pc_seq(bus.IFpc);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         refill_q <= '0;
      end else begin
         state_q  <= state_d;
         refill_q <= refill_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      refill_d = refill_q;
      case (state_q)
         ST_RUN: begin
            if (mispredict) begin
               state_d = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            state_d  = ST_REFILL;
            refill_d = REFILL_LOAD;
         end
         ST_REFILL: begin
            // A stalled refill cycle does not consume a refill slot.
            if (!bus.stall) begin
               if (refill_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  refill_d = refill_q - 1'b1;
               end
            end
         end
         default: begin
            state_d  = ST_RUN;
            refill_d = '0;
         end
      endcase
   end

   always_comb begin
      bus.next_pc = seq_pc;
      bus.pc_we   = 1'b1;
      bus.flush   = 1'b0;
      if (!rst_n) begin
         bus.next_pc = RESET_PC;
         bus.pc_we   = 1'b0;
         bus.flush   = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mispredict) begin
                  bus.next_pc = correction_pc;
                  bus.flush   = 1'b1;
               end else if (bus.stall) begin
                  bus.next_pc = bus.IFpc;
                  bus.pc_we   = 1'b0;
               end else if (bus.IFpcchoose) begin
                  bus.next_pc = bus.IFnpc;
               end
            end
            ST_REDIRECT: begin
               bus.flush = 1'b1;
            end
            ST_REFILL: begin
               bus.pc_we = !bus.stall;
            end
            default: begin
               bus.pc_we = 1'b0;
            end
         endcase
      end
   end

   assign bus.state = state_q;

   redirect_ctrl_sat_counter u_branch_cnt (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .inc_i   (resolve),
      .cnt_o   (bus.branch_cnt)
   );

   redirect_ctrl_sat_counter u_mispred_cnt (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .inc_i   (mispredict),
      .cnt_o   (bus.mispred_cnt)
   );

endmodule

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 Parameter REFILL_CYCLES, default 2, legal range 1..7: number of cycles after a redirect during which BHT predictions are ignored.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: value driven on next_pc while reset is asserted.
REQ-003 clk_sys  in  1  system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  pipeline hazard stall request.
REQ-006 IFpc  in  32  current fetch PC.
REQ-007 IFpcchoose  in  1  BHT predicts taken for IFpc.
REQ-008 IFnpc  in  32  BHT predicted target.
REQ-009 Ex_valid  in  1  EX stage holds a resolved branch or jump.
REQ-010 Expc  in  32  PC of the EX instruction.
REQ-011 Exnpc  in  32  actual taken target of the EX instruction.
REQ-012 Expcchoose  in  1  EX instruction was predicted taken.
REQ-013 isjmp  in  1  EX instruction actually taken.
REQ-014 next_pc  out  32  PC value to load.
REQ-015 pc_we  out  1  PC register write enable.
REQ-016 flush  out  1  clear the IF/ID and ID/EX registers.
REQ-017 state  out  2  FSM state (RUN=0, REDIRECT=1, REFILL=2).
REQ-018 branch_cnt  out  16  count of accepted resolutions.
REQ-019 mispred_cnt  out  16  count of mispredictions.

Function
REQ-020 A misprediction is defined as Ex_valid=1 with Expcchoose!=isjmp, in state RUN only.
REQ-021 The correction target is Exnpc when isjmp=1, and Expc+4 (modulo 2^32) when isjmp=0.
REQ-022 In RUN, the output priority is misprediction, then stall, then IF prediction, then sequential.
REQ-023 RUN with a misprediction: next_pc=correction target, pc_we=1 and flush=1 in the same cycle, regardless of stall; next state REDIRECT.
REQ-024 RUN with stall=1 and no misprediction: pc_we=0, flush=0, next_pc=IFpc.
REQ-025 RUN otherwise: pc_we=1, flush=0; next_pc=IFnpc if IFpcchoose=1, else IFpc+4.
REQ-026 REDIRECT lasts exactly one cycle: flush=1, pc_we=1, next_pc=IFpc+4; IFpcchoose is ignored; next state REFILL with the counter loaded to REFILL_CYCLES-1.
REQ-027 REFILL: flush=0, IFpcchoose is ignored, next_pc=IFpc+4, pc_we=!stall.
REQ-028 In REFILL, the counter decrements only when stall=0; on a counter value of 0 with stall=0, the next state is RUN.
REQ-029 In REDIRECT and REFILL, Ex_valid is ignored: these are bubbles, with no counting and no redirect.
REQ-030 branch_cnt increments by 1 on each RUN cycle with Ex_valid=1.
REQ-031 mispred_cnt increments by 1 on each misprediction.
REQ-032 branch_cnt and mispred_cnt both saturate at 16'hFFFF and never wrap.
REQ-033 All PC arithmetic is 32-bit and wraps silently: 32'hFFFF_FFFC+4 = 0.
REQ-034 next_pc, pc_we and flush are combinational from the state and the inputs; state, the counter and the statistics counters are registered.

Reset
REQ-035 While rst_n=0: state=RUN, refill counter=0, branch_cnt=0, mispred_cnt=0, next_pc=RESET_PC, pc_we=0, flush=1.
REQ-036 Reset asserted during REDIRECT or REFILL immediately aborts the sequence; after release the block is in RUN with no pending redirect.
REQ-037 The first rising edge after release behaves per RUN.

Structure
REQ-038 A shared package holds the state encoding constants, the PC increment constant (4) and the counter width (16).
REQ-039 Natural sub-module: sat_counter (16-bit, increment enable, saturating, async active-low clear), instantiated twice.
REQ-040 The FSM and next-PC multiplexer reside in redirect_ctrl itself.

Verification
REQ-041 Sequential: IFpc=0x100, IFpcchoose=0, Ex_valid=0 -> next_pc=0x104, pc_we=1, flush=0, state=RUN.
REQ-042 Not-taken mispredict: Ex_valid=1, Expcchoose=0, isjmp=1, Exnpc=0x400 -> next_pc=0x400, flush=1 that cycle and the next, then REFILL for 2 cycles, then RUN; mispred_cnt=1, branch_cnt=1.
REQ-043 Taken mispredict: Expcchoose=1, isjmp=0, Expc=0x200, with stall=1 -> next_pc=0x204, pc_we=1 (stall overridden), state goes to REDIRECT.
REQ-044 Stall in REFILL: stall=1 for 3 cycles in REFILL -> pc_we=0 and the counter frozen; RUN is reached only after 2 unstalled REFILL cycles; IFpcchoose=1 with IFnpc=0x800 during REFILL is ignored.
REQ-045 Saturation: force mispred_cnt to 16'hFFFE, then apply 3 mispredictions separated by the full sequence -> mispred_cnt holds at 16'hFFFF.
REQ-046 Reset mid-REFILL: drop rst_n -> state=RUN, flush=1, pc_we=0, next_pc=RESET_PC asynchronously; counters are cleared.
